// File: rtl/cyc_counters_dumper.sv
// cyc_counters_dumper
//   Walks the cycle-accounting counter bank over its SRAM-like CSR port and
//   streams a tear-free 64-bit snapshot of every counter on a valid/ready
//   interface. The status register is saved first and written back at the end,
//   so counting resumes on the originally enabled counter.
//
//   XLEN selects the counter-interface data width (32 or 64) and stands in for
//   CVA6Cfg.XLEN of the core configuration.
//
//   Optional feature, macro CYC_DUMP_CLEAR_EN: when defined, every counter is
//   cleared right after it has been captured (clear-on-read dump). When it is
//   undefined, the only bank writes are the select writes and the final
//   status restore.
module cyc_counters_dumper #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned CycAccountRegs = 8,
    parameter logic [11:0] CsrCntStatus   = 12'h7C0,
    parameter logic [11:0] CsrCntData     = 12'h7C1,
    parameter logic [11:0] CsrCntDataH    = 12'h7C2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [11:0]     addr_o,
    output logic            we_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [XLEN-1:0] rdata_i,
    output logic            snap_valid_o,
    input  logic            snap_ready_i,
    output logic [15:0]     snap_idx_o,
    output logic [63:0]     snap_data_o
);

    localparam logic [15:0] LastIdx = 16'(CycAccountRegs - 1);
    localparam bit          Wide    = (XLEN == 64);

    // S_RD is the single-cycle 64-bit read; S_HI1/S_LO/S_HI2 form the
    // high-low-high sequence that makes a 32-bit read of a running counter
    // tear-free.
    typedef enum logic [3:0] {
        S_IDLE,
        S_SAVE,
        S_SEL,
        S_RD,
        S_HI1,
        S_LO,
        S_HI2,
        S_PUSH,
        S_RESTORE
`ifdef CYC_DUMP_CLEAR_EN
        ,
        S_CLR,
        S_CLR_HI
`endif
    } state_t;

    // State reached once a counter value has been captured.
`ifdef CYC_DUMP_CLEAR_EN
    localparam state_t CapNext = S_CLR;
`else
    localparam state_t CapNext = S_PUSH;
`endif

    state_t      state_reg, state_next;
    logic [31:0] orig_reg, orig_next;
    logic [15:0] idx_reg, idx_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [63:0] data_reg, data_next;

    logic [63:0] rdata_ext;
    logic [63:0] wdata_full;
    logic [31:0] rdata_lo;

    // Read data widened to 64 bits so both widths share one datapath.
    generate
        if (XLEN == 64) begin : g_rd64
            assign rdata_ext = rdata_i;
        end else begin : g_rd32
            assign rdata_ext = {32'h0, rdata_i};
        end
    endgenerate

    assign rdata_lo    = rdata_ext[31:0];
    assign wdata_o     = wdata_full[XLEN-1:0];
    assign snap_idx_o  = idx_reg;
    assign snap_data_o = data_reg;
    assign busy_o      = (state_reg != S_IDLE);

    // State and capture registers; reset mid-dump drops straight to idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
            orig_reg  <= 32'h0;
            idx_reg   <= 16'h0;
            hi_reg    <= 32'h0;
            lo_reg    <= 32'h0;
            data_reg  <= 64'h0;
        end else begin
            state_reg <= state_next;
            orig_reg  <= orig_next;
            idx_reg   <= idx_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            data_reg  <= data_next;
        end
    end

    // Next-state logic and bank/stream outputs; idle drives a status read.
    always_comb begin
        state_next   = state_reg;
        orig_next    = orig_reg;
        idx_next     = idx_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        data_next    = data_reg;
        addr_o       = CsrCntStatus;
        we_o         = 1'b0;
        wdata_full   = 64'h0;
        snap_valid_o = 1'b0;
        done_o       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_SAVE;
                end
            end

            S_SAVE: begin
                // Status is on rdata_i already because idle/save address it.
                orig_next  = rdata_lo;
                idx_next   = 16'h0;
                state_next = S_SEL;
            end

            S_SEL: begin
                // Keep the enabled counter, only retarget the read selector.
                we_o       = 1'b1;
                wdata_full = {32'h0, orig_reg[31:16], idx_reg};
                state_next = Wide ? S_RD : S_HI1;
            end

            S_RD: begin
                addr_o     = CsrCntData;
                data_next  = rdata_ext;
                state_next = CapNext;
            end

            S_HI1: begin
                addr_o     = CsrCntDataH;
                hi_next    = rdata_lo;
                state_next = S_LO;
            end

            S_LO: begin
                addr_o     = CsrCntData;
                lo_next    = rdata_lo;
                state_next = S_HI2;
            end

            S_HI2: begin
                // An unchanged high word proves the low word did not wrap
                // between the two high reads; otherwise re-read the low word.
                addr_o = CsrCntDataH;
                if (rdata_lo == hi_reg) begin
                    data_next  = {hi_reg, lo_reg};
                    state_next = CapNext;
                end else begin
                    hi_next    = rdata_lo;
                    state_next = S_LO;
                end
            end

`ifdef CYC_DUMP_CLEAR_EN
            S_CLR: begin
                we_o       = 1'b1;
                addr_o     = CsrCntData;
                state_next = Wide ? S_PUSH : S_CLR_HI;
            end

            S_CLR_HI: begin
                we_o       = 1'b1;
                addr_o     = CsrCntDataH;
                state_next = S_PUSH;
            end
`endif

            S_PUSH: begin
                // Bank stays untouched while the sink stalls.
                snap_valid_o = 1'b1;
                if (snap_ready_i) begin
                    if (idx_reg == LastIdx) begin
                        state_next = S_RESTORE;
                    end else begin
                        idx_next   = 16'(idx_reg + 16'd1);
                        state_next = S_SEL;
                    end
                end
            end

            S_RESTORE: begin
                we_o       = 1'b1;
                wdata_full = {32'h0, orig_reg};
                done_o     = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cyc_counters_dumper.sv
// Bench for cyc_counters_dumper: one 64-bit and one 32-bit instance, each
// attached to a behavioural counter bank. Snapshots, bank writes, latency and
// the final bank state are checked against rules computed in the bench.
module tb_cyc_counters_dumper;

    localparam int N = 4;
    localparam logic [15:0] N16 = 16'd4;
    localparam logic [11:0] A_STAT  = 12'h7C0;
    localparam logic [11:0] A_DATA  = 12'h7C1;
    localparam logic [11:0] A_DATAH = 12'h7C2;
`ifdef CYC_DUMP_CLEAR_EN
    localparam int ClrW64 = 1;
    localparam int ClrW32 = 2;
`else
    localparam int ClrW64 = 0;
    localparam int ClrW32 = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start [2];
    logic        busy  [2];
    logic        done  [2];
    logic        we    [2];
    logic        valid [2];
    logic        ready [2];
    logic [11:0] addr  [2];
    logic [15:0] sidx  [2];
    logic [63:0] sdata [2];
    logic [63:0] wdata_a, rdata_a;
    logic [31:0] wdata_b, rdata_b;
    logic [63:0] wd    [2];
    logic [63:0] cur   [2];

    // bank model state
    logic [63:0] cnt     [2][N];
    logic [31:0] stat    [2];
    logic [63:0] last_rd [2][N];
    int          wr_total [2] = '{0, 0};

    // stimulus-owned
    logic [63:0] init      [2][N];
    logic [31:0] dump_stat [2] = '{32'h0, 32'h0};
    logic        load_req  [2] = '{1'b0, 1'b0};
    int          rmode = 0;

    // monitor-owned
    int          exp_idx    [2] = '{0, 0};
    int          done_total [2] = '{0, 0};
    int          stalled    [2] = '{0, 0};
    logic        pv         [2] = '{1'b0, 1'b0};
    logic [15:0] pidx       [2];
    logic [63:0] pdata      [2];
    logic [63:0] snap_log   [2][N];

    int checks = 0;
    int errors = 0;

    cyc_counters_dumper #(.XLEN(64), .CycAccountRegs(N)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .busy_o(busy[0]),
        .done_o(done[0]), .addr_o(addr[0]), .we_o(we[0]), .wdata_o(wdata_a),
        .rdata_i(rdata_a), .snap_valid_o(valid[0]), .snap_ready_i(ready[0]),
        .snap_idx_o(sidx[0]), .snap_data_o(sdata[0])
    );

    cyc_counters_dumper #(.XLEN(32), .CycAccountRegs(N)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .busy_o(busy[1]),
        .done_o(done[1]), .addr_o(addr[1]), .we_o(we[1]), .wdata_o(wdata_b),
        .rdata_i(rdata_b), .snap_valid_o(valid[1]), .snap_ready_i(ready[1]),
        .snap_idx_o(sidx[1]), .snap_data_o(sdata[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Bank read side: data combinational on the address.
    always_comb begin
        wd[0] = wdata_a;
        wd[1] = {32'h0, wdata_b};
        for (int u = 0; u < 2; u++) begin
            cur[u] = (stat[u][15:0] < N16) ? cnt[u][stat[u][1:0]] : 64'h0;
        end
        rdata_a = 64'h0;
        case (addr[0])
            A_STAT:  rdata_a = {32'h0, stat[0]};
            A_DATA:  rdata_a = cur[0];
            A_DATAH: rdata_a = {32'h0, cur[0][63:32]};
            default: rdata_a = 64'h0;
        endcase
        rdata_b = 32'h0;
        case (addr[1])
            A_STAT:  rdata_b = stat[1];
            A_DATA:  rdata_b = cur[1][31:0];
            A_DATAH: rdata_b = cur[1][63:32];
            default: rdata_b = 32'h0;
        endcase
    end

    // Bank update side: writes land on the edge, else the enabled counter counts.
    always @(posedge clk) begin
        logic [15:0] en_v;
        logic [15:0] sel_v;
        for (int u = 0; u < 2; u++) begin
            en_v  = stat[u][31:16];
            sel_v = stat[u][15:0];
            if (load_req[u]) begin
                for (int i = 0; i < N; i++) cnt[u][i] <= init[u][i];
                stat[u] <= dump_stat[u];
            end else if (we[u]) begin
                wr_total[u] <= wr_total[u] + 1;
                case (addr[u])
                    A_STAT: stat[u] <= wd[u][31:0];
                    A_DATA: begin
                        if (sel_v < N16) begin
                            if (u == 0) cnt[u][sel_v[1:0]] <= wd[u];
                            else        cnt[u][sel_v[1:0]][31:0] <= wd[u][31:0];
                        end
                    end
                    A_DATAH: begin
                        if (sel_v < N16) cnt[u][sel_v[1:0]][63:32] <= wd[u][31:0];
                    end
                    default: ;
                endcase
            end else begin
                if (en_v < N16) cnt[u][en_v[1:0]] <= cnt[u][en_v[1:0]] + 64'd1;
                if (addr[u] == A_DATA && sel_v < N16) last_rd[u][sel_v[1:0]] <= cnt[u][sel_v[1:0]];
            end
        end
    end

    // Sink ready generation plus every-cycle stream/bus checks.
    always @(negedge clk) begin
        int k;
        logic [63:0] exp_d;
        for (int u = 0; u < 2; u++) begin
            case (rmode)
                0: begin ready[u] = 1'b1; stalled[u] = 0; end
                1: begin ready[u] = ($urandom_range(0, 2) != 0); stalled[u] = 0; end
                default: begin
                    if (valid[u] && sidx[u] == 16'd1 && stalled[u] < 5) begin
                        ready[u] = 1'b0;
                        stalled[u]++;
                    end else begin
                        ready[u] = 1'b1;
                    end
                end
            endcase
            if (!rst_n) begin
                exp_idx[u] = 0;
                pv[u] = 1'b0;
            end else begin
                if (pv[u]) begin
                    chk("stall_valid", 64'(valid[u]), 64'd1);
                    chk("stall_idx", 64'(sidx[u]), 64'(pidx[u]));
                    chk("stall_data", sdata[u], pdata[u]);
                end
                if (valid[u]) begin
                    chk("push_we", 64'(we[u]), 64'd0);
                    chk("push_addr", 64'(addr[u]), 64'(A_STAT));
                    chk("push_busy", 64'(busy[u]), 64'd1);
                end
                if (we[u]) begin
                    if (addr[u] == A_STAT) begin
                        chk("wr_en_field", 64'(wd[u][31:16]), 64'(dump_stat[u][31:16]));
                    end else begin
                        chk("clr_data", wd[u], 64'h0);
`ifndef CYC_DUMP_CLEAR_EN
                        chk("wr_addr", 64'(addr[u]), 64'(A_STAT));
`endif
                    end
                end
                if (valid[u] && ready[u]) begin
                    k = exp_idx[u] % N;
                    exp_d = (16'(exp_idx[u]) == dump_stat[u][31:16]) ? last_rd[u][k] : init[u][k];
                    chk("snap_idx", 64'(sidx[u]), 64'(exp_idx[u]));
                    chk("snap_data", sdata[u], exp_d);
                    snap_log[u][k] = sdata[u];
                    $display("snap inst=%0d idx=%0d data=0x%016h", u, sidx[u], sdata[u]);
                    exp_idx[u]++;
                end
                if (done[u]) begin
                    chk("done_snaps", 64'(exp_idx[u]), 64'(N));
                    chk("restore_we", 64'(we[u]), 64'd1);
                    chk("restore_data", wd[u], {32'h0, dump_stat[u]});
                    exp_idx[u] = 0;
                    done_total[u]++;
                end
                pv[u]    = valid[u] && !ready[u];
                pidx[u]  = sidx[u];
                pdata[u] = sdata[u];
            end
        end
    end

    task automatic chk_reset(input int u);
        chk("rst_busy", 64'(busy[u]), 64'd0);
        chk("rst_done", 64'(done[u]), 64'd0);
        chk("rst_valid", 64'(valid[u]), 64'd0);
        chk("rst_we", 64'(we[u]), 64'd0);
        chk("rst_wdata", wd[u], 64'h0);
        chk("rst_addr", 64'(addr[u]), 64'(A_STAT));
        chk("rst_idx", 64'(sidx[u]), 64'd0);
        chk("rst_data", sdata[u], 64'h0);
    endtask

    // One full dump on instance u with status st; exp_lat <= 0 skips latency.
    task automatic dump(input int u, input logic [31:0] st, input int exp_lat, input bit ghost);
        int base_done;
        int base_wr;
        int lat;
        bit got;
        logic [15:0] en;
        en = st[31:16];
        @(negedge clk);
        dump_stat[u] = st;
        load_req[u]  = 1'b1;
        @(negedge clk);
        load_req[u] = 1'b0;
        base_done = done_total[u];
        base_wr   = wr_total[u];
        start[u]  = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 600 && !got; c++) begin
            @(negedge clk);
            if (done[u]) begin
                got = 1'b1;
                lat = c;
            end
            start[u] = ghost && (done[u] || $urandom_range(0, 3) == 0);
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
        if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
`ifdef CYC_DUMP_CLEAR_EN
        if (u == 0 && en < N16) chk("clr_bound", 64'(cnt[u][en[1:0]] < 64'(2 * N + 4)), 64'd1);
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start[u] = 1'b0;
            chk("idle_busy", 64'(busy[u]), 64'd0);
        end
        chk("done_count", 64'(done_total[u] - base_done), 64'd1);
        chk("write_count", 64'(wr_total[u] - base_wr),
            64'(N + 1 + N * ((u == 0) ? ClrW64 : ClrW32)));
        chk("status_restored", 64'(stat[u]), 64'(st));
        for (int i = 0; i < N; i++) begin
            if (16'(i) != en) begin
`ifdef CYC_DUMP_CLEAR_EN
                chk("idle_counter", cnt[u][i], 64'h0);
`else
                chk("idle_counter", cnt[u][i], init[u][i]);
`endif
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < N; i++) init[u][i] = 64'h0;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 64-bit walk: counter 2 counts 6 times before its read cycle
        rmode = 0;
        init[0] = '{64'd10, 64'd20, 64'd30, 64'd40};
        dump(0, 32'h0002_0001, 2 + (3 + ClrW64) * N, 1'b0);
        chk("dir_snap0", snap_log[0][0], 64'd10);
        chk("dir_snap1", snap_log[0][1], 64'd20);
        chk("dir_snap2", snap_log[0][2], 64'd36);
        chk("dir_snap3", snap_log[0][3], 64'd40);

        // sink stalls for 5 cycles at index 1
        rmode = 2;
        init[0] = '{64'h1111_0000_0000_0001, 64'h2222, 64'h3333, 64'hFFFF_FFFF_FFFF_FF00};
        dump(0, 32'h0001_0003, 2 + (3 + ClrW64) * N + 5, 1'b0);
        chk("stall_cycles", 64'(stalled[0]), 64'd5);
        rmode = 0;

        // 32-bit carry: counter 0 is 0xFFFF_FFFE at the first high read,
        // wraps before the second one, so exactly one retry happens
        init[1] = '{64'h0000_0000_FFFF_FFFC, 64'h5, 64'h6, 64'h7};
        dump(1, 32'h0000_0000, 2 + (5 + ClrW32) * N + 2, 1'b0);
        chk("carry_snap", snap_log[1][0], 64'h0000_0001_0000_0001);

        // stray start pulses while busy and in the done cycle
        init[1] = '{64'h100, 64'h200, 64'h300, 64'h400};
        dump(1, 32'h0003_0002, 2 + (5 + ClrW32) * N, 1'b1);
        init[0] = '{64'h7, 64'h8, 64'h9, 64'hA};
        dump(0, 32'h0000_0002, 2 + (3 + ClrW64) * N, 1'b1);

        // reset in the middle of a dump
        @(negedge clk);
        dump_stat[0] = 32'h0001_0000;
        load_req[0] = 1'b1;
        @(negedge clk);
        load_req[0] = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(busy[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // randomized dumps with random backpressure
        rmode = 1;
        for (int t = 0; t < 10; t++) begin
            int u;
            logic [31:0] st;
            u = int'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                init[u][i] = {32'($urandom), 32'($urandom)};
                if ($urandom_range(0, 1) == 1) init[u][i][31:0] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            st = {16'($urandom_range(0, N)), 16'($urandom_range(0, N - 1))};
            dump(u, st, 0, 1'($urandom_range(0, 1)));
        end
        rmode = 0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
